snow64_bfloat16_from_int: RTL and testbench

Multi-cycle converter from a 64-bit integer (signed or unsigned) to BFloat16 (1 sign, 8 exponent bits with bias 127, 7 mantissa bits). It is the producing counterpart of the BFloat16 comparator: the comparator consumes BFloat16 values and yields a boolean, while this block manufactures BFloat16 operands from integer registers for the scalar/vector FP path. It uses an iterative normalizer with a start/valid command handshake, the same style as the other multi-cycle BFloat16 units.

---
 rtl/snow64_bfloat16_from_int_pkg.sv | 32 +++
 rtl/snow64_bfloat16_from_int.sv | 103 ++++++++++
 tb/tb_snow64_bfloat16_from_int.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/snow64_bfloat16_from_int_pkg.sv
// Shared BFloat16 types and constants for the integer-to-BFloat16 converter.
// The command and result bundles mirror the top-level port groups.
package snow64_bfloat16_from_int_pkg;

   localparam int BFLOAT16_EXP_BIAS = 127;
   localparam int FROM_INT_EXP_SEED = BFLOAT16_EXP_BIAS + 63;

   typedef enum logic [1:0] {
      IDLE,
      NORMALIZE,
      DONE
   } StateFromInt;

   typedef struct packed {
      logic       sign;
      logic [7:0] enc_exp;
      logic [6:0] enc_mantissa;
   } BFloat16;

   typedef struct packed {
      logic        start;
      logic        is_signed;
      logic [63:0] data;
   } PortIn_FromInt;

   typedef struct packed {
      logic        can_accept_cmd;
      logic        data_valid;
      logic [15:0] data;
   } PortOut_FromInt;

endpackage

// File: rtl/snow64_bfloat16_from_int.sv
// Iterative 64-bit integer to BFloat16 converter with a start/valid handshake.
// Normalizes by byte or single-bit shifts, then truncates to a 7-bit mantissa.
module snow64_bfloat16_from_int
   import snow64_bfloat16_from_int_pkg::*;
#(
   parameter int WIDTH__INT = 64,
   parameter int EXP_SEED   = FROM_INT_EXP_SEED
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_start,
   input  logic                  in_is_signed,
   input  logic [WIDTH__INT-1:0] in_data,
   output logic                  out_can_accept_cmd,
   output logic                  out_data_valid,
   output logic [15:0]           out_data
);

   StateFromInt    state_q, state_d;
   logic           sign_q, sign_d;
   logic [63:0]    mag_q, mag_d;
   logic [7:0]     exp_q, exp_d;
   logic [15:0]    out_data_q, out_data_d;
   PortIn_FromInt  port_in;
   PortOut_FromInt port_out;
   BFloat16        result;

   assign port_in.start     = in_start;
   assign port_in.is_signed = in_is_signed;
   assign port_in.data      = in_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sign_q     <= 1'b0;
         mag_q      <= '0;
         exp_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         mag_q      <= mag_d;
         exp_q      <= exp_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      mag_d      = mag_q;
      exp_d      = exp_q;
      out_data_d = out_data_q;
      result     = '0;
      case (state_q)
         IDLE: begin
            if (port_in.start) begin
               sign_d  = port_in.is_signed & port_in.data[63];
               mag_d   = sign_d ? (64'd0 - port_in.data) : port_in.data;
               exp_d   = 8'(EXP_SEED);
               state_d = NORMALIZE;
            end
         end
         NORMALIZE: begin
            // Zero converts to +0 regardless of sign; otherwise shift until bit 63 leads.
            if (mag_q == 64'd0) begin
               out_data_d = 16'h0000;
               state_d    = DONE;
            end else if (mag_q[63]) begin
               result.sign         = sign_q;
               result.enc_exp      = exp_q;
               result.enc_mantissa = mag_q[62:56];
               out_data_d          = result;
               state_d             = DONE;
            end else if (mag_q[63:56] == 8'd0) begin
               mag_d = {mag_q[55:0], 8'd0};
               exp_d = exp_q - 8'd8;
            end else begin
               mag_d = {mag_q[62:0], 1'b0};
               exp_d = exp_q - 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      port_out                = '0;
      port_out.can_accept_cmd = (state_q == IDLE);
      port_out.data_valid     = (state_q == DONE);
      port_out.data           = out_data_q;
   end

   assign out_can_accept_cmd = port_out.can_accept_cmd;
   assign out_data_valid     = port_out.data_valid;
   assign out_data           = port_out.data;

endmodule

// File: tb/tb_snow64_bfloat16_from_int.sv
// Scoreboard bench for snow64_bfloat16_from_int: stimulus pushes expected results,
// an independent monitor pops and compares whenever a valid pulse appears.
module tb_snow64_bfloat16_from_int;

   logic        clk;
   logic        rst;
   logic        inStart;
   logic        inIsSigned;
   logic [63:0] inData;
   logic        outCanAccept;
   logic        outDataValid;
   logic [15:0] outData;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int tagCount = 0;

   typedef struct {
      logic [15:0] data;
      int          acceptCyc;
      int          expCyc;
      int          tag;
   } ExpT;

   ExpT expQ[$];

   snow64_bfloat16_from_int dut (
      .clk                (clk),
      .rst                (rst),
      .in_start           (inStart),
      .in_is_signed       (inIsSigned),
      .in_data            (inData),
      .out_can_accept_cmd (outCanAccept),
      .out_data_valid     (outDataValid),
      .out_data           (outData)
   );

   // Clock stays idle for the first 20ns so reset can be checked without edges.
   initial begin
      clk = 1'b0;
      #20;
      forever #5 clk = ~clk;
   end

   // Free-running cycle counter used to measure result latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Watchdog so the run always terminates even if the design stalls.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares one observed value against the value the bench requires.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Reference model: locate the leading one and keep the next seven bits, truncating.
   function automatic logic [15:0] modelBf16(input bit isSigned, input logic [63:0] d);
      logic        neg;
      logic [63:0] mag;
      logic [63:0] mant;
      int          p;
      int          e;
      neg = isSigned && d[63];
      mag = neg ? (64'd0 - d) : d;
      if (mag == 64'd0) return 16'h0000;
      p = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      e = 127 + p;
      if (p >= 7) mant = (mag >> (p - 7)) & 64'h7F;
      else        mant = (mag << (7 - p)) & 64'h7F;
      return {neg, e[7:0], mant[6:0]};
   endfunction

   // Shift steps: one per leading zero byte, then one per remaining leading zero bit.
   function automatic int modelSteps(input bit isSigned, input logic [63:0] d);
      logic [63:0] mag;
      int          lz;
      mag = (isSigned && d[63]) ? (64'd0 - d) : d;
      if (mag == 64'd0) return 0;
      lz = 0;
      for (int i = 63; i >= 0; i--) begin
         if (mag[i]) break;
         lz++;
      end
      return lz / 8 + lz % 8;
   endfunction

   // Called at a negedge; waits for the converter to be idle, then issues one command.
   task automatic applyStimulus(input bit s, input logic [63:0] d, input logic [15:0] expData,
                                input int steps);
      int waitCnt;
      waitCnt = 0;
      while (!outCanAccept && waitCnt < 100) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!outCanAccept) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout: got can_accept=0 want 1 within 100 cycles");
         return;
      end
      inStart    = 1'b1;
      inIsSigned = s;
      inData     = d;
      tagCount++;
      expQ.push_back('{expData, cyc, cyc + 2 + steps, tagCount});
      @(negedge clk);
      inStart = 1'b0;
      inData  = {$urandom, $urandom};
   endtask

   // Waits for the scoreboard to empty, with a bounded cycle budget.
   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout: got %0d pending results want 0", expQ.size());
         expQ.delete();
      end
   endtask

   // Monitor: checks busy behaviour and pops one expectation per valid pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (expQ.size() > 0 && cyc > expQ[0].acceptCyc)
            checkOutput("busy_can_accept", {63'd0, outCanAccept}, 64'd0);
         if (outDataValid) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_valid: got valid=1 data=%0h want no pulse", outData);
            end else begin
               ExpT e;
               e = expQ.pop_front();
               checkOutput($sformatf("data#%0d", e.tag), {48'd0, outData}, {48'd0, e.data});
               checkOutput($sformatf("latency#%0d", e.tag), 64'(cyc), 64'(e.expCyc));
            end
         end
      end
   end

   // Main stimulus sequence: reset, directed values, reset abort, held start, random.
   initial begin
      logic [63:0] d;
      bit          s;
      rst        = 1'b1;
      inStart    = 1'b0;
      inIsSigned = 1'b0;
      inData     = '0;
      #10;
      checkOutput("reset_can_accept", {63'd0, outCanAccept}, 64'd1);
      checkOutput("reset_valid", {63'd0, outDataValid}, 64'd0);
      checkOutput("reset_data", {48'd0, outData}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(1'b0, 64'd1, 16'h3F80, 14);
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 16'hBF80, 14);
      applyStimulus(1'b0, 64'd300, 16'h4396, 13);
      applyStimulus(1'b0, 64'd511, 16'h43FF, 13);
      applyStimulus(1'b1, 64'h8000_0000_0000_0000, 16'hDF00, 0);
      applyStimulus(1'b0, 64'h8000_0000_0000_0000, 16'h5F00, 0);
      applyStimulus(1'b1, 64'd0, 16'h0000, 0);
      applyStimulus(1'b0, 64'd0, 16'h0000, 0);
      applyStimulus(1'b1, 64'd300, 16'h4396, 13);
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FED4, 16'hC396, 13);
      waitDrain();

      // Leave a nonzero result on the output so the abort check is meaningful.
      applyStimulus(1'b0, 64'd511, 16'h43FF, 13);
      waitDrain();
      applyStimulus(1'b0, 64'd1, 16'h3F80, 14);
      repeat (4) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort_can_accept", {63'd0, outCanAccept}, 64'd1);
      checkOutput("abort_valid", {63'd0, outDataValid}, 64'd0);
      checkOutput("abort_data", {48'd0, outData}, 64'd0);
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Start held high with changing data: only idle-cycle values are accepted.
      for (int i = 0; i < 80; i++) begin
         s          = 1'($urandom);
         d          = {$urandom, $urandom} >> $urandom_range(0, 63);
         inStart    = 1'b1;
         inIsSigned = s;
         inData     = d;
         if (outCanAccept) begin
            tagCount++;
            expQ.push_back('{modelBf16(s, d), cyc, cyc + 2 + modelSteps(s, d), tagCount});
         end
         @(negedge clk);
      end
      inStart = 1'b0;
      waitDrain();

      for (int i = 0; i < 3000; i++) begin
         s = 1'($urandom);
         d = {$urandom, $urandom} >> $urandom_range(0, 63);
         if (s && $urandom_range(0, 1) == 1) d = 64'd0 - d;
         applyStimulus(s, d, modelBf16(s, d), modelSteps(s, d));
      end
      waitDrain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
